// File: rtl/harvard_mem_pkg.sv
// Shared types and helpers for the Harvard memory responder.
// Holds the FSM state encoding, default address map and word indexing.
package harvard_mem_pkg;

   typedef enum logic [2:0] {
      CLEAR,
      LOAD,
      RELEASE,
      RUN,
      FAULT
   } state_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC00000;
   localparam logic [31:0] DEF_DATA_BASE    = 32'h00001000;

   typedef struct packed {
      logic        in_range;
      logic [31:0] index;
   } widx_t;

   // Word index of addr relative to base. in_range only says
   // addr >= base; the caller bounds index against its depth.
   function automatic widx_t word_index(
      input logic [31:0] addr,
      input logic [31:0] base
   );
      widx_t       r;
      logic [31:0] off;
      off        = addr - base;
      r.in_range = (addr >= base);
      r.index    = {2'b00, off[31:2]};
      return r;
   endfunction

endpackage

// File: rtl/harvard_word_ram.sv
// Word RAM: synchronous write, combinational read, no array reset.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module harvard_word_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/harvard_mem_responder.sv
// Responder for Harvard CPU instruction/data ports with image loader.
// Ports: clk, reset (async, low), load_* byte stream, cpu_reset,
// load_done, instr_* read port, data_* read/write port, fault/fault_addr.
module harvard_mem_responder
   import harvard_mem_pkg::*;
#(
   parameter int          ADDR_W       = 10,
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] DATA_BASE    = DEF_DATA_BASE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [7:0]  load_byte,
   input  logic        load_last,
   output logic        load_ready,
   output logic        cpu_reset,
   output logic        load_done,
   input  logic [31:0] instr_address,
   output logic [31:0] instr_readdata,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam logic [31:0] DEPTH = 32'(2**ADDR_W);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W:0]   word_cnt;
   logic [1:0]        byte_cnt;
   logic [31:0]       acc_q;
   logic              rel_cnt;
   logic              fault_run;

   widx_t       iw, dw;
   logic        i_ok, d_ok, d_acc, d_bad;
   logic        take, word_full, word_wr;
   logic [31:0] acc_d, imem_rd, dmem_rd;
   logic        dmem_we;
   logic [ADDR_W-1:0] dmem_wa;
   logic [31:0] dmem_wd;

   assign iw   = word_index(instr_address, RESET_VECTOR);
   assign dw   = word_index(data_address, DATA_BASE);
   assign i_ok = iw.in_range && (iw.index < DEPTH);
   assign d_ok = dw.in_range && (dw.index < DEPTH)
              && (data_address[1:0] == 2'b00)
              && !(data_read && data_write);
   assign d_acc = data_read || data_write;
   assign d_bad = (state_q == RUN) && d_acc && !d_ok;

   // Big-endian packing: byte k of a word lands at [31-8k -: 8].
   assign take      = (state_q == LOAD) && load_valid;
   assign word_full = word_cnt[ADDR_W];
   assign acc_d     = acc_q
                    | ({load_byte, 24'h0} >> {byte_cnt, 3'b000});
   assign word_wr   = take && !word_full
                    && ((byte_cnt == 2'd3) || load_last);

   always_comb begin
      dmem_we = 1'b0;
      dmem_wa = dw.index[ADDR_W-1:0];
      dmem_wd = data_writedata;
      if (state_q == CLEAR) begin
         dmem_we = 1'b1;
         dmem_wa = clr_cnt;
         dmem_wd = '0;
      end else if (state_q == RUN) begin
         dmem_we = data_write && d_ok;
      end
   end

   harvard_word_ram #(.ADDR_W(ADDR_W)) imem (
      .clk   (clk),
      .we    (word_wr),
      .waddr (word_cnt[ADDR_W-1:0]),
      .wdata (acc_d),
      .raddr (iw.index[ADDR_W-1:0]),
      .rdata (imem_rd)
   );

   harvard_word_ram #(.ADDR_W(ADDR_W)) dmem (
      .clk   (clk),
      .we    (dmem_we),
      .waddr (dmem_wa),
      .wdata (dmem_wd),
      .raddr (dw.index[ADDR_W-1:0]),
      .rdata (dmem_rd)
   );

   assign instr_readdata = i_ok ? imem_rd : '0;
   assign data_readdata  = (data_read && d_ok) ? dmem_rd : '0;

   assign load_ready = (state_q == LOAD);
   assign cpu_reset  = (state_q != RUN);
   assign load_done  = (state_q == RUN)
                    || ((state_q == FAULT) && fault_run);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CLEAR:   if (clr_cnt == '1) state_d = LOAD;
         LOAD: begin
            if (take && word_full)     state_d = FAULT;
            else if (take && load_last) state_d = RELEASE;
         end
         RELEASE: if (rel_cnt) state_d = RUN;
         RUN:     if (d_bad) state_d = FAULT;
         FAULT:   state_d = FAULT;
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= CLEAR;
         clr_cnt    <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         acc_q      <= '0;
         rel_cnt    <= 1'b0;
         fault_run  <= 1'b0;
         fault      <= 1'b0;
         fault_addr <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR)   clr_cnt <= clr_cnt + ADDR_W'(1);
         if (state_q == RELEASE) rel_cnt <= 1'b1;
         if (take && !word_full) begin
            if (word_wr) begin
               word_cnt <= word_cnt + (ADDR_W+1)'(1);
               byte_cnt <= '0;
               acc_q    <= '0;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               acc_q    <= acc_d;
            end
         end
         if (take && word_full) begin
            fault      <= 1'b1;
            fault_addr <= RESET_VECTOR + 32'({word_cnt, 2'b00});
         end
         if (d_bad) begin
            fault      <= 1'b1;
            fault_addr <= data_address;
            fault_run  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_harvard_mem_responder.sv
// Bench for harvard_mem_responder with ADDR_W=4.
// Reference model plus expected-value queue for read ports.
module tb_harvard_mem_responder;

   localparam int          AW = 4;
   localparam int          DEP = 16;
   localparam logic [31:0] RV = 32'hBFC00000;
   localparam logic [31:0] DB = 32'h00001000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_valid = 1'b0;
   logic [7:0]  load_byte = '0;
   logic        load_last = 1'b0;
   logic        load_ready, cpu_reset, load_done;
   logic [31:0] instr_address = '0;
   logic [31:0] instr_readdata;
   logic [31:0] data_address = '0;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_writedata = '0;
   logic [31:0] data_readdata;
   logic        fault;
   logic [31:0] fault_addr;

   always #5 clk = ~clk;

   harvard_mem_responder #(
      .ADDR_W(AW), .RESET_VECTOR(RV), .DATA_BASE(DB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .load_valid     (load_valid),
      .load_byte      (load_byte),
      .load_last      (load_last),
      .load_ready     (load_ready),
      .cpu_reset      (cpu_reset),
      .load_done      (load_done),
      .instr_address  (instr_address),
      .instr_readdata (instr_readdata),
      .data_address   (data_address),
      .data_read      (data_read),
      .data_write     (data_write),
      .data_writedata (data_writedata),
      .data_readdata  (data_readdata),
      .fault          (fault),
      .fault_addr     (fault_addr)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t         sbq[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mimem [DEP];
   logic [31:0] mdmem [DEP];
   int          mwc, mbc;
   logic [31:0] macc;
   logic        mfault;
   logic [31:0] mfaddr;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic sb_cmp(logic [31:0] got);
      sb_t e;
      if (sbq.size() == 0) begin
         check("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         check(e.tag, got, e.exp);
      end
   endtask

   function automatic logic [31:0] exp_instr(logic [31:0] a);
      logic [31:0] i;
      i = (a - RV) >> 2;
      if (a >= RV && i < DEP) return mimem[i];
      return 32'h0;
   endfunction

   function automatic logic d_legal(logic [31:0] a, logic rd, logic wr);
      return (a[1:0] == 2'b00) && (a >= DB)
          && (((a - DB) >> 2) < DEP) && !(rd && wr);
   endfunction

   task automatic do_reset();
      int n;
      reset = 1'b0;
      load_valid = 1'b0;
      load_last = 1'b0;
      data_read = 1'b0;
      data_write = 1'b0;
      #2;
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_load_ready", 32'(load_ready), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_fault_addr", fault_addr, 32'h0);
      for (int i = 0; i < DEP; i++) mdmem[i] = 32'h0;
      mwc = 0;
      mbc = 0;
      macc = 32'h0;
      mfault = 1'b0;
      mfaddr = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!load_ready && n < 100);
      check("clear_len", 32'(n), 32'd16);
   endtask

   task automatic send_byte(logic [7:0] b, logic last);
      load_valid = 1'b1;
      load_byte = b;
      load_last = last;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_last = 1'b0;
      if (mwc == DEP) begin
         mfault = 1'b1;
         mfaddr = RV + 32'(4 * mwc);
      end else begin
         macc = macc | ({b, 24'h0} >> (8 * mbc));
         if (mbc == 3 || last) begin
            mimem[mwc] = macc;
            mwc++;
            mbc = 0;
            macc = 32'h0;
         end else begin
            mbc++;
         end
      end
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (cpu_reset && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("release_len", 32'(n), 32'd2);
      check("run_load_done", 32'(load_done), 32'd1);
   endtask

   task automatic read_instr(logic [31:0] a);
      instr_address = a;
      sbq.push_back('{$sformatf("instr_%08h", a), exp_instr(a)});
      @(negedge clk);
      sb_cmp(instr_readdata);
      @(posedge clk);
      #1;
   endtask

   task automatic data_op(logic [31:0] a, logic rd, logic wr,
                          logic [31:0] wd);
      logic        ok;
      logic [31:0] i;
      ok = d_legal(a, rd, wr);
      i = (a - DB) >> 2;
      data_address = a;
      data_read = rd;
      data_write = wr;
      data_writedata = wd;
      sbq.push_back('{$sformatf("data_%08h", a),
                      (rd && ok) ? mdmem[i] : 32'h0});
      @(negedge clk);
      sb_cmp(data_readdata);
      @(posedge clk);
      #1;
      data_read = 1'b0;
      data_write = 1'b0;
      if (!mfault) begin
         if ((rd || wr) && !ok) begin
            mfault = 1'b1;
            mfaddr = a;
         end else if (wr) begin
            mdmem[i] = wd;
         end
      end
   endtask

   task automatic check_fault(string tag);
      check({tag, "_fault"}, 32'(fault), 32'(mfault));
      check({tag, "_faddr"}, fault_addr, mfaddr);
   endtask

   logic [7:0] img1 [8];
   logic [7:0] img2 [5];

   initial begin
      img1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      img2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

      // 1: two full words
      do_reset();
      for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
      check("t1_cpu_reset_hold", 32'(cpu_reset), 32'd1);
      wait_run();
      read_instr(RV);
      read_instr(RV + 32'd4);

      // 2: padded partial word and out-of-range fetches
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(img2[i], i == 4);
      wait_run();
      read_instr(RV);
      read_instr(RV + 32'h4);
      read_instr(RV + 32'h40);
      read_instr(RV - 32'h4);

      // 3: write, read-back, boundary reads
      data_op(DB + 32'h8, 1'b0, 1'b1, 32'hDEADBEEF);
      data_op(DB + 32'h8, 1'b1, 1'b0, 32'h0);
      data_op(DB, 1'b1, 1'b0, 32'h0);
      data_op(DB + 32'h3C, 1'b1, 1'b0, 32'h0);
      check_fault("t3");

      // 4: misaligned read faults; later writes blocked
      data_op(DB + 32'h2, 1'b1, 1'b0, 32'h0);
      check_fault("t4");
      check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t4_load_done", 32'(load_done), 32'd1);
      data_op(DB, 1'b0, 1'b1, 32'h12345678);
      check_fault("t4_hold");
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(img2[i], i == 4);
      wait_run();
      data_op(DB, 1'b1, 1'b0, 32'h0);

      // 5: image overflow
      do_reset();
      for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
      check("t5_ready_pre", 32'(load_ready), 32'd1);
      check_fault("t5_pre");
      send_byte(8'h41, 1'b0);
      check_fault("t5");
      check("t5_ready", 32'(load_ready), 32'd0);
      check("t5_load_done", 32'(load_done), 32'd0);
      check("t5_cpu_reset", 32'(cpu_reset), 32'd1);

      // 6: reset mid-load, reload, out-of-range write
      do_reset();
      for (int i = 0; i < 3; i++) send_byte(img1[i], 1'b0);
      reset = 1'b0;
      #1;
      check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
      check("t6_ready", 32'(load_ready), 32'd0);
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b1);
      wait_run();
      read_instr(RV);
      data_op(DB + 32'h40, 1'b0, 1'b1, 32'h55AA55AA);
      check_fault("t6");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=0", n_checks);
      $fatal(1, "timeout");
   end

endmodule
